fpmult_iter_radix: RTL
======================

FPMULT_ITER_RADIX -- requirements
Module: fpmult_iter_radix

Interface
REQ-001 Parameter n, default 32, total operand/result width in bits.
REQ-002 Parameter d, default 16, fractional bits; SHALL satisfy 0 <= d < n.
REQ-003 Parameter sign, default 1: 1 means two's-complement operands, 0 means unsigned.
REQ-004 Parameter k, default 4: multiplier bits retired per cycle; SHALL divide n; elaboration SHALL fail otherwise.
REQ-005 Parameter round, default 0: 0 truncates; 1 rounds half-up by adding 2^(d-1) before the shift.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 recv_val  input  1  operands a/b valid.
REQ-009 recv_rdy  output  1  block can accept operands.
REQ-010 a  input  n  multiplicand.
REQ-011 b  input  n  multiplier.
REQ-012 send_val  output  1  result c valid.
REQ-013 send_rdy  input  1  consumer accepts c.
REQ-014 c  output  n  fixed-point product.

Function
REQ-015 The block SHALL compute c = (a*b + R) >> d, where the product is exact at 2n bits and R = 2^(d-1) if round=1 and d>0, else 0.
REQ-016 When sign=1, a and b SHALL be interpreted as signed; the top digit of b SHALL carry negative weight on its MSB.
REQ-017 The FSM SHALL have states IDLE, CALC and DONE; recv_rdy=1 only in IDLE, and send_val=1 only in DONE.
REQ-018 IDLE->CALC SHALL occur on the edge where recv_val&recv_rdy; a, b are captured, the accumulator is set to R, and the digit counter is set to 0.
REQ-019 Each CALC cycle SHALL add the a-times-digit partial product, shifted k*counter, to a 2n-bit accumulator and increment the counter.
REQ-020 CALC->DONE SHALL occur on the edge that retires digit n/k-1; c is registered on that same edge.
REQ-021 Latency SHALL be fixed: send_val rises exactly n/k edges after the accepting edge, independent of operand values.
REQ-022 In DONE, c SHALL be held stable until send_val&send_rdy; on that edge the FSM returns to IDLE.
REQ-023 There SHALL be no same-cycle pass-through: a new operand is accepted no earlier than one edge after the result handshake.
REQ-024 recv_val SHALL be ignored outside IDLE, and send_rdy SHALL be ignored outside DONE.
REQ-025 Wrap mode: c SHALL be bits [n+d-1:d] of the rounded accumulator.

Reset
REQ-026 Reset SHALL force IDLE, recv_rdy=1, send_val=0, c=0, accumulator=0 and counter=0.
REQ-027 Reset asserted mid-CALC or mid-DONE SHALL discard the operation; no result is emitted.
REQ-028 Reset SHALL take priority over a simultaneous handshake.

Configuration
REQ-029 With FPMULT_SATURATE_EN defined, c SHALL clamp to the most positive or most negative n-bit value when the rounded product >> d is out of range.
REQ-030 For sign=0, clamping SHALL be to all-ones; all other behaviour is unchanged.
REQ-031 Without FPMULT_SATURATE_EN, REQ-025 wrap SHALL apply and no saturation logic SHALL exist.

Structure
REQ-032 Package fpmult_pkg SHALL hold the FSM state enum and the width helper functions for digit count and accumulator width.
REQ-033 Sub-module fpmult_digit SHALL be combinational.
REQ-034 fpmult_digit inputs: a, digit, counter, acc, last-digit flag; output: next acc.
REQ-035 fpmult_digit SHALL apply the signed-MSB correction.

Verification (n=32, d=16, sign=1, k=4 unless noted)
REQ-036 a=0x00018000, b=0x00020000 -> c=0x00030000; send_val rises 8 edges after acceptance.
REQ-037 a=0xFFFF0000, b=0x00008000 -> c=0xFFFF8000; also k=1 -> same c after 32 edges.
REQ-038 a=0x7FFF0000, b=0x00020000 -> c=0x7FFFFFFF with FPMULT_SATURATE_EN, 0xFFFE0000 without.
REQ-039 a=0x00000001, b=0x00008000: round=0 -> c=0x00000000; round=1 -> c=0x00000001.
REQ-040 Hold send_rdy low 5 cycles in DONE -> c and send_val stable, recv_rdy=0; recv_val pulses are ignored.
REQ-041 Assert reset at CALC cycle 3 -> next edge recv_rdy=1, send_val=0, c=0; no stale result appears later.

Source files
------------

// File: rtl/fpmult_pkg.sv
// Shared types and width helpers for the iterative radix-2^k fixed-point multiplier.
package fpmult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int num_digits(input int n, input int k);
        return n / k;
    endfunction

    function automatic int acc_width(input int n);
        return 2 * n;
    endfunction

    function automatic int cnt_width(input int n, input int k);
        return (n / k > 1) ? $clog2(n / k) : 1;
    endfunction

endpackage

// File: rtl/fpmult_digit.sv
// One radix-2^k step: adds a * digit, weighted by 2^(k*cnt), into the 2n-bit accumulator.
module fpmult_digit
    import fpmult_pkg::*;
#(
    parameter int n    = 32,
    parameter int k    = 4,
    parameter int sign = 1,
    parameter int CW   = 3
) (
    input  logic [n-1:0]              a_i,
    input  logic [k-1:0]              digit_i,
    input  logic [CW-1:0]             cnt_i,
    input  logic [acc_width(n)-1:0]   acc_i,
    input  logic                      last_i,
    output logic [acc_width(n)-1:0]   acc_o
);

    localparam int AW = acc_width(n);

    logic [AW-1:0] a_ext;
    logic [AW-1:0] pp;
    logic [AW-1:0] corr;
    logic [31:0]   shamt;

    always_comb begin
        a_ext = (sign != 0) ? {{n{a_i[n-1]}}, a_i} : {{n{1'b0}}, a_i};
        pp    = a_ext * AW'(digit_i);
        // Top digit of a signed multiplier: its MSB weighs -2^(k-1), so remove 2*2^(k-1)*a.
        corr  = '0;
        if (sign != 0 && last_i && digit_i[k-1])
            corr = a_ext << k;
        shamt = k * 32'(cnt_i);
        acc_o = acc_i + ((pp - corr) << shamt);
    end

endmodule

// File: rtl/fpmult_iter_radix.sv
// Iterative fixed-point multiplier, k multiplier bits per cycle, valid/ready on both sides.
// Define FPMULT_SATURATE_EN to clamp out-of-range results instead of wrapping.
module fpmult_iter_radix
    import fpmult_pkg::*;
#(
    parameter int n     = 32,
    parameter int d     = 16,
    parameter int sign  = 1,
    parameter int k     = 4,
    parameter int round = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] c
);

    localparam int ND  = num_digits(n, k);
    localparam int CW  = cnt_width(n, k);
    localparam int AW  = acc_width(n);
    localparam int RSH = (d > 0) ? d - 1 : 0;
    localparam logic [AW-1:0] RVAL = (round != 0 && d > 0) ? (AW'(1) << RSH) : '0;

    if (k <= 0 || (n % k) != 0) begin : g_bad_k
        $error("fpmult_iter_radix: k must divide n");
    end
    if (d < 0 || d >= n) begin : g_bad_d
        $error("fpmult_iter_radix: d must satisfy 0 <= d < n");
    end

    state_e          state_q, state_d;
    logic [n-1:0]    a_q, a_d;
    logic [n-1:0]    b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [n-1:0]    c_q, c_d;

    logic [k-1:0]    digit;
    logic            last;
    logic [AW-1:0]   acc_nxt;
    logic [n-1:0]    res;

    assign digit = k'(b_q >> (k * 32'(cnt_q)));
    assign last  = (cnt_q == CW'(ND - 1));

    fpmult_digit #(
        .n    (n),
        .k    (k),
        .sign (sign),
        .CW   (CW)
    ) u_digit (
        .a_i     (a_q),
        .digit_i (digit),
        .cnt_i   (cnt_q),
        .acc_i   (acc_q),
        .last_i  (last),
        .acc_o   (acc_nxt)
    );

`ifdef FPMULT_SATURATE_EN
    if (sign != 0) begin : g_sat_s
        // In range only when every bit from n+d-1 upward is a copy of the sign.
        logic [AW-n-d:0] hi;
        assign hi  = acc_nxt[AW-1:n+d-1];
        assign res = (&hi || ~|hi) ? acc_nxt[n+d-1:d]
                   : (acc_nxt[AW-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}});
    end else begin : g_sat_u
        logic [AW-n-d-1:0] hi;
        assign hi  = acc_nxt[AW-1:n+d];
        assign res = (|hi) ? {n{1'b1}} : acc_nxt[n+d-1:d];
    end
`else
    assign res = acc_nxt[n+d-1:d];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        unique case (state_q)
            ST_IDLE: begin
                if (recv_val) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = RVAL;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    c_d     = res;
                end
            end
            ST_DONE: begin
                if (send_rdy)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign recv_rdy = (state_q == ST_IDLE);
    assign send_val = (state_q == ST_DONE);
    assign c        = c_q;

endmodule
